apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the ACCESS-phase wait limit in pclk_i cycles (range 2..255).
REQ-002 pclk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 presetn_i  input  1  reset, SHALL be asynchronous and active-low.
REQ-004 reqN_i (N=0,1)  input  1  requester N transaction request, held high until doneN_o.
REQ-005 wrN_i  input  1  requester N direction (1 = write, 0 = read), valid while reqN_i.
REQ-006 addrN_i  input  8  requester N APB address, valid while reqN_i.
REQ-007 wdataN_i  input  32  requester N write data, valid while reqN_i.
REQ-008 gntN_o  output  1  high from the SETUP cycle through the ACCESS completion cycle of N's transfer.
REQ-009 doneN_o  output  1  one-cycle pulse marking completion of N's transfer.
REQ-010 rdataN_o  output  32  read data for N, valid while doneN_o.
REQ-011 errN_o  output  1  error flag for N, valid while doneN_o.
REQ-012 psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-013 paddr_o  output  8  APB address; pwdata_o  output  32  APB write data.
REQ-014 prdata_i  input  32, pready_i  input  1, pslverr_i  input  1  APB slave response.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, ACCESS; all outputs SHALL be registered.
REQ-016 IDLE: if any unmasked reqN_i is high, the arbiter SHALL select a winner, capture its wr/addr/wdata and go to SETUP next cycle; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requesting, the requester not served last wins; a single requester wins unconditionally.
REQ-018 SETUP (exactly one cycle): psel_o=1, penable_o=0, paddr_o/pwrite_o from captured values, pwdata_o=captured wdata for writes and 0 for reads; next state ACCESS.
REQ-019 ACCESS: psel_o=1, penable_o=1, address/control/data SHALL remain stable until pready_i=1.
REQ-020 On ACCESS with pready_i=1 the FSM SHALL return to IDLE; the next cycle doneN_o=1 for one cycle, rdataN_o=prdata_i (reads) or 0 (writes), errN_o=pslverr_i, gntN_o=0.
REQ-021 In the cycle doneN_o=1, reqN_i SHALL be masked from arbitration; the other requester MAY win in that cycle.
REQ-022 Minimum transfer is 3 cycles (IDLE decision, SETUP, ACCESS); back-to-back transfers SHALL be separated by one IDLE cycle.
REQ-023 Outputs of the non-granted requester SHALL stay 0 (done, err) and hold their last rdata value.
REQ-024 Requests changing while not granted SHALL have no effect on an in-flight transfer.

Reset
REQ-025 presetn_i low SHALL immediately force state IDLE and every output to 0, including mid-transfer (psel_o drops without completion; no doneN_o issued).
REQ-026 After reset the round-robin pointer SHALL favour requester 0.

Configuration
REQ-027 Macro APB_ARBITER_TIMEOUT_EN defined: an ACCESS-cycle counter SHALL, after TIMEOUT_CYCLES ACCESS cycles without pready_i, abort to IDLE and pulse doneN_o with errN_o=1, rdataN_o=0.
REQ-028 Macro undefined: no counter exists; ACCESS SHALL wait indefinitely for pready_i.

Verification
REQ-029 req0 read addr 0x10, pready_i=1 in first ACCESS, prdata_i=0xDEADBEEF -> psel high 2 cycles, done0 pulse, rdata0_o=0xDEADBEEF, err0_o=0.
REQ-030 req0 and req1 raised same cycle after reset, both writes -> requester 0 served first, requester 1 second, one IDLE cycle between, pwdata_o matches each.
REQ-031 req1 write addr 0x05 with pready_i low 3 ACCESS cycles, pslverr_i=1 on completion -> paddr_o stable 0x05 throughout, done1 with err1_o=1.
REQ-032 presetn_i asserted during ACCESS -> psel_o/penable_o/gnt drop to 0 asynchronously, no doneN_o, next transfer starts from IDLE.
REQ-033 With APB_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready_i held low -> done0 with err0_o=1, rdata0_o=0 after 4 ACCESS cycles; without macro, transfer remains in ACCESS.

Source files
------------

// File: rtl/apb_arbiter.sv
`default_nettype none
// ============================================================================
// apb_arbiter: two-requester round-robin APB master with registered outputs.
// Optional ACCESS timeout enabled by macro APB_ARBITER_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
module apb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic        req0_i,
  input  logic        wr0_i,
  input  logic [7:0]  addr0_i,
  input  logic [31:0] wdata0_i,
  input  logic        req1_i,
  input  logic        wr1_i,
  input  logic [7:0]  addr1_i,
  input  logic [31:0] wdata1_i,
  output logic        gnt0_o,
  output logic        done0_o,
  output logic [31:0] rdata0_o,
  output logic        err0_o,
  output logic        gnt1_o,
  output logic        done1_o,
  output logic [31:0] rdata1_o,
  output logic        err1_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [7:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        last, last_nxt;          // 1: requester 1 was served most recently
  logic        req0_ok, req1_ok, pick1;
  logic        complete, cpl_err;
  logic [31:0] cpl_data;

  logic        psel_nxt, penable_nxt, pwrite_nxt;
  logic [7:0]  paddr_nxt;
  logic [31:0] pwdata_nxt;
  logic        gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err0_nxt, err1_nxt;
  logic [31:0] rdata0_nxt, rdata1_nxt;

`ifdef APB_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt, cnt_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    psel_nxt    = psel_o;
    penable_nxt = penable_o;
    pwrite_nxt  = pwrite_o;
    paddr_nxt   = paddr_o;
    pwdata_nxt  = pwdata_o;
    gnt0_nxt    = gnt0_o;
    gnt1_nxt    = gnt1_o;
    done0_nxt   = 1'b0;
    done1_nxt   = 1'b0;
    err0_nxt    = 1'b0;
    err1_nxt    = 1'b0;
    rdata0_nxt  = rdata0_o;
    rdata1_nxt  = rdata1_o;
    complete    = 1'b0;
    cpl_err     = 1'b0;
    cpl_data    = '0;
`ifdef APB_ARBITER_TIMEOUT_EN
    cnt_nxt     = cnt;
`endif
    // A requester whose done pulse is showing is still holding req high.
    req0_ok = req0_i & ~done0_o;
    req1_ok = req1_i & ~done1_o;
    pick1   = req1_ok & (~req0_ok | ~last);

    case (state)
      IDLE: begin
        if (req0_ok | req1_ok) begin
          state_nxt   = SETUP;
          last_nxt    = pick1;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          gnt0_nxt    = ~pick1;
          gnt1_nxt    = pick1;
          pwrite_nxt  = pick1 ? wr1_i : wr0_i;
          paddr_nxt   = pick1 ? addr1_i : addr0_i;
          if (pick1) pwdata_nxt = wr1_i ? wdata1_i : '0;
          else       pwdata_nxt = wr0_i ? wdata0_i : '0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
`ifdef APB_ARBITER_TIMEOUT_EN
        cnt_nxt     = '0;
`endif
      end
      ACCESS: begin
        if (pready_i) begin
          complete = 1'b1;
          cpl_err  = pslverr_i;
          cpl_data = pwrite_o ? '0 : prdata_i;
        end
`ifdef APB_ARBITER_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          complete = 1'b1;
          cpl_err  = 1'b1;
          cpl_data = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
`endif
        if (complete) begin
          state_nxt   = IDLE;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          gnt0_nxt    = 1'b0;
          gnt1_nxt    = 1'b0;
          if (gnt1_o) begin
            done1_nxt  = 1'b1;
            err1_nxt   = cpl_err;
            rdata1_nxt = cpl_data;
          end else begin
            done0_nxt  = 1'b1;
            err0_nxt   = cpl_err;
            rdata0_nxt = cpl_data;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state     <= IDLE;
      last      <= 1'b1;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      gnt0_o    <= 1'b0;
      gnt1_o    <= 1'b0;
      done0_o   <= 1'b0;
      done1_o   <= 1'b0;
      err0_o    <= 1'b0;
      err1_o    <= 1'b0;
      rdata0_o  <= '0;
      rdata1_o  <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      psel_o    <= psel_nxt;
      penable_o <= penable_nxt;
      pwrite_o  <= pwrite_nxt;
      paddr_o   <= paddr_nxt;
      pwdata_o  <= pwdata_nxt;
      gnt0_o    <= gnt0_nxt;
      gnt1_o    <= gnt1_nxt;
      done0_o   <= done0_nxt;
      done1_o   <= done1_nxt;
      err0_o    <= err0_nxt;
      err1_o    <= err1_nxt;
      rdata0_o  <= rdata0_nxt;
      rdata1_o  <= rdata1_nxt;
    end
  end

`ifdef APB_ARBITER_TIMEOUT_EN
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) cnt <= '0;
    else            cnt <= cnt_nxt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_apb_arbiter: directed self-checking bench for apb_arbiter.
// Revision 1.0
// ============================================================================
module tb_apb_arbiter;

  logic        pclk_i = 1'b0;
  logic        presetn_i;
  logic        req0_i, wr0_i, req1_i, wr1_i;
  logic [7:0]  addr0_i, addr1_i;
  logic [31:0] wdata0_i, wdata1_i;
  logic        gnt0_o, done0_o, err0_o, gnt1_o, done1_o, err1_o;
  logic [31:0] rdata0_o, rdata1_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [7:0]  paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i, pslverr_i;

  int checks   = 0;
  int failures = 0;

  apb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .pclk_i(pclk_i), .presetn_i(presetn_i),
    .req0_i(req0_i), .wr0_i(wr0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .req1_i(req1_i), .wr1_i(wr1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .gnt0_o(gnt0_o), .done0_o(done0_o), .rdata0_o(rdata0_o), .err0_o(err0_o),
    .gnt1_o(gnt1_o), .done1_o(done1_o), .rdata1_o(rdata1_o), .err1_o(err1_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge pclk_i);
    #1;
  endtask

  initial begin
    presetn_i = 1'b0;
    req0_i = 0; wr0_i = 0; addr0_i = '0; wdata0_i = '0;
    req1_i = 0; wr1_i = 0; addr1_i = '0; wdata1_i = '0;
    prdata_i = '0; pready_i = 0; pslverr_i = 0;
    step(); step();
    chk("rst_psel", psel_o, 0);
    chk("rst_gnt", {gnt1_o, gnt0_o}, 0);
    chk("rst_done", {done1_o, done0_o, err1_o, err0_o}, 0);
    chk("rst_rdata0", rdata0_o, 0);
    presetn_i = 1'b1;

    // Single read by requester 0
    req0_i = 1; wr0_i = 0; addr0_i = 8'h10;
    step();
    chk("rd_setup_psel", {psel_o, penable_o}, 2'b10);
    chk("rd_setup_gnt0", gnt0_o, 1);
    chk("rd_setup_addr", paddr_o, 8'h10);
    chk("rd_setup_pwdata", pwdata_o, 0);
    step();
    chk("rd_access", {psel_o, penable_o}, 2'b11);
    pready_i = 1; prdata_i = 32'hDEADBEEF;
    step();
    chk("rd_done0", done0_o, 1);
    chk("rd_rdata0", rdata0_o, 32'hDEADBEEF);
    chk("rd_err0", err0_o, 0);
    chk("rd_psel_drop", {psel_o, gnt0_o}, 0);
    pready_i = 0; prdata_i = '0;
    step();
    chk("rd_mask_no_regrant", psel_o, 0);
    chk("rd_done_pulse", done0_o, 0);
    req0_i = 0;

    // Simultaneous writes right after reset
    presetn_i = 0; step(); presetn_i = 1;
    req0_i = 1; wr0_i = 1; addr0_i = 8'h20; wdata0_i = 32'h11111111;
    req1_i = 1; wr1_i = 1; addr1_i = 8'h30; wdata1_i = 32'h22222222;
    step();
    chk("both_first_gnt", {gnt1_o, gnt0_o}, 2'b01);
    chk("both_first_addr", paddr_o, 8'h20);
    chk("both_first_pwrite", pwrite_o, 1);
    chk("both_first_pwdata", pwdata_o, 32'h11111111);
    step();
    pready_i = 1;
    step();
    pready_i = 0;
    chk("both_done0", {done1_o, done0_o}, 2'b01);
    chk("both_wr_rdata0", rdata0_o, 0);
    chk("both_gap_psel", psel_o, 0);
    step();
    req0_i = 0;
    chk("both_second_setup", {psel_o, penable_o}, 2'b10);
    chk("both_second_gnt", {gnt1_o, gnt0_o}, 2'b10);
    chk("both_second_addr", paddr_o, 8'h30);
    chk("both_second_pwdata", pwdata_o, 32'h22222222);
    step();
    pready_i = 1;
    step();
    pready_i = 0;
    chk("both_done1", {done1_o, done0_o}, 2'b10);
    chk("both_err1", err1_o, 0);
    step();
    chk("both_mask1", psel_o, 0);
    req1_i = 0;

    // Requester 1 write with wait states and slave error
    req1_i = 1; wr1_i = 1; addr1_i = 8'h05; wdata1_i = 32'hCAFE0005;
    step();
    chk("ws_setup_gnt1", gnt1_o, 1);
    chk("ws_setup_addr", paddr_o, 8'h05);
    step();
    req0_i = 1; wr0_i = 0; addr0_i = 8'h77;
    chk("ws_acc1_addr", paddr_o, 8'h05);
    chk("ws_acc1_en", penable_o, 1);
    step();
    chk("ws_acc2_addr", paddr_o, 8'h05);
    chk("ws_acc2_gnt", {gnt1_o, gnt0_o}, 2'b10);
    step();
    chk("ws_acc3_addr", paddr_o, 8'h05);
    chk("ws_acc3_pwdata", pwdata_o, 32'hCAFE0005);
    step();
    chk("ws_acc4_addr", paddr_o, 8'h05);
    pready_i = 1; pslverr_i = 1;
    step();
    pready_i = 0; pslverr_i = 0;
    chk("ws_done1", {done1_o, done0_o}, 2'b10);
    chk("ws_err1", {err1_o, err0_o}, 2'b10);
    chk("ws_rdata1", rdata1_o, 0);
    step();
    req1_i = 0;
    chk("nxt0_gnt", {gnt1_o, gnt0_o}, 2'b01);
    chk("nxt0_addr", paddr_o, 8'h77);
    step();
    chk("nxt0_access", {psel_o, penable_o}, 2'b11);

    // Asynchronous reset during ACCESS
    #3 presetn_i = 0;
    #1;
    chk("arst_bus", {psel_o, penable_o}, 0);
    chk("arst_gnt", {gnt1_o, gnt0_o}, 0);
    step();
    chk("arst_no_done", {done1_o, done0_o}, 0);
    req0_i = 0;
    presetn_i = 1;

    // Fresh read after reset
    req0_i = 1; wr0_i = 0; addr0_i = 8'h40;
    step();
    chk("post_setup", {psel_o, penable_o, gnt0_o}, 3'b101);
    chk("post_addr", paddr_o, 8'h40);
    step();
    pready_i = 1; prdata_i = 32'hA5A5A5A5;
    step();
    pready_i = 0; prdata_i = 32'h12345678;
    chk("post_done0", done0_o, 1);
    chk("post_rdata0", rdata0_o, 32'hA5A5A5A5);
    step();
    chk("post_mask", psel_o, 0);
    addr0_i = 8'h44;

    // Slave never ready
    step();
    chk("to_setup_addr", paddr_o, 8'h44);
    step();
    chk("to_acc1", {psel_o, penable_o}, 2'b11);
    step();
    step();
    step();
    chk("to_acc4", {psel_o, penable_o}, 2'b11);
    step();
`ifdef APB_ARBITER_TIMEOUT_EN
    chk("to_done0", done0_o, 1);
    chk("to_err0", err0_o, 1);
    chk("to_rdata0", rdata0_o, 0);
    chk("to_psel", psel_o, 0);
`else
    chk("nto_still_access", {psel_o, penable_o}, 2'b11);
    chk("nto_no_done", done0_o, 0);
    chk("nto_rdata_hold", rdata0_o, 32'hA5A5A5A5);
    for (int i = 0; i < 10; i++) step();
    chk("nto_still_access_late", {psel_o, penable_o, gnt0_o}, 3'b111);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
